// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response channel plus the decode-side handshake.
// The master modport is the fetch stage; the slave modport is memory plus decode.
interface if_prefetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction fetch front end: owns the fetch PC, keeps one imem request in flight
// and queues fetched {pc, instr} pairs for decode; a redirect flushes and refetches.
module if_prefetch_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  if_prefetch_stage_if.master bus
);
  localparam int              PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]     FULL_CNT   = (PW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            drop;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic [XLEN-1:0] pc_q    [FIFO_DEPTH];
  logic [31:0]     instr_q [FIFO_DEPTH];

  logic req_fire;
  logic rsp_take;
  logic push;
  logic pop;

  // A slot is always free for the single in-flight response, since requests stop at full.
  assign bus.imem_req_valid = !rst && !redirect_valid && !outstanding && (count < FULL_CNT);
  assign bus.imem_req_addr  = rst ? RESET_PC : fetch_pc;
  assign bus.id_valid       = !rst && !redirect_valid && (count != '0);
  assign bus.id_instr       = rst ? '0 : instr_q[rd_ptr];
  assign bus.id_pc          = rst ? '0 : pc_q[rd_ptr];
  assign bus.id_pc_plus4    = rst ? '0 : pc_q[rd_ptr] + XLEN'(4);

  always_comb begin
    req_fire = bus.imem_req_valid && bus.imem_req_ready;
    rsp_take = bus.imem_rsp_valid && outstanding;
    push     = rsp_take && !drop && !redirect_valid && !rst;
    pop      = bus.id_valid && bus.id_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A response landing with the redirect is already stale; otherwise mark the in-flight one.
      if (rsp_take) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        drop <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end else if (rsp_take) begin
        outstanding <= 1'b0;
      end
      if (rsp_take) drop <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= req_pc;
      instr_q[wr_ptr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a default-PC instance exercised through stall,
// redirect and reset scenarios, and a wrap-around RESET_PC instance free-running alongside.
module tb_if_prefetch_stage;
  logic        clk;
  logic        rst;
  logic        rv1, rv2;
  logic [31:0] rpc1, rpc2;
  int          n_assert = 0;
  int          n_fail   = 0;

  int          lat1 = 1, lat2 = 1;
  int          rem1 = 0, rem2 = 0;
  logic [31:0] pa1, pa2;

  if_prefetch_stage_if #(.XLEN(32)) b1 ();
  if_prefetch_stage_if #(.XLEN(32)) b2 ();

  if_prefetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .redirect_valid(rv1), .redirect_pc(rpc1), .bus(b1)
  );
  if_prefetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(rv2), .redirect_pc(rpc2), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; also plays instruction memory for both instances (data = C0DE:addr[15:0]).
  task automatic cyc();
    logic        f1, f2;
    logic [31:0] a1, a2;
    #1;
    f1 = (b1.imem_req_valid === 1'b1) && (b1.imem_req_ready === 1'b1);
    f2 = (b2.imem_req_valid === 1'b1) && (b2.imem_req_ready === 1'b1);
    a1 = b1.imem_req_addr;
    a2 = b2.imem_req_addr;
    @(posedge clk);
    #1;
    b1.imem_rsp_valid = 1'b0;
    b2.imem_rsp_valid = 1'b0;
    if (f1) begin rem1 = lat1; pa1 = a1; end
    if (f2) begin rem2 = lat2; pa2 = a2; end
    if (rem1 > 0) begin
      rem1--;
      if (rem1 == 0) begin b1.imem_rsp_valid = 1'b1; b1.imem_rsp_data = {16'hC0DE, pa1[15:0]}; end
    end
    if (rem2 > 0) begin
      rem2--;
      if (rem2 == 0) begin b2.imem_rsp_valid = 1'b1; b2.imem_rsp_data = {16'hC0DE, pa2[15:0]}; end
    end
  endtask

  task automatic wait_id(input string tag);
    int n;
    n = 0;
    #1;
    while (b1.id_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk(tag, {31'd0, b1.id_valid}, 32'd1);
  endtask

  logic [31:0] exp_pc1 [3];
  logic [31:0] exp_pc2 [3];
  logic [31:0] exp_p42 [3];

  initial begin
    exp_pc1 = '{32'h0, 32'h4, 32'h8};
    exp_pc2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_p42 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst = 1'b1;
    rv1 = 1'b0; rv2 = 1'b0; rpc1 = '0; rpc2 = '0;
    b1.imem_req_ready = 1'b1; b1.imem_rsp_valid = 1'b0; b1.imem_rsp_data = '0; b1.id_ready = 1'b1;
    b2.imem_req_ready = 1'b1; b2.imem_rsp_valid = 1'b0; b2.imem_rsp_data = '0; b2.id_ready = 1'b1;

    // Reset state
    cyc();
    chk("rst_req_valid", {31'd0, b1.imem_req_valid}, 32'd0);
    chk("rst_req_addr",  b1.imem_req_addr, 32'h0);
    chk("rst_id_valid",  {31'd0, b1.id_valid}, 32'd0);
    chk("rst_id_instr",  b1.id_instr, 32'h0);
    chk("rst_id_pc",     b1.id_pc, 32'h0);
    chk("rst_id_pc4",    b1.id_pc_plus4, 32'h0);
    chk("rst2_req_addr", b2.imem_req_addr, 32'hFFFF_FFF8);
    chk("rst2_req_valid", {31'd0, b2.imem_req_valid}, 32'd0);

    // Free run, k=1; the wrap instance runs in lockstep
    rst = 1'b0;
    #1;
    chk("run_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("run_req_addr",  b1.imem_req_addr, 32'h0);
    chk("run2_req_addr", b2.imem_req_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      wait_id("run_id_valid");
      chk("run_id_pc",    b1.id_pc, exp_pc1[i]);
      chk("run_id_instr", b1.id_instr, {16'hC0DE, exp_pc1[i][15:0]});
      chk("run_id_pc4",   b1.id_pc_plus4, exp_pc1[i] + 32'd4);
      chk("wrap_id_valid", {31'd0, b2.id_valid}, 32'd1);
      chk("wrap_id_pc",    b2.id_pc, exp_pc2[i]);
      chk("wrap_id_instr", b2.id_instr, {16'hC0DE, exp_pc2[i][15:0]});
      chk("wrap_id_pc4",   b2.id_pc_plus4, exp_p42[i]);
      cyc();
    end

    // Stall: fill 4 entries, then drain in order and resume at 0x10
    rst = 1'b1;
    b1.id_ready = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i >= 7) begin
        chk("stall_req_valid", {31'd0, b1.imem_req_valid}, 32'd0);
        chk("stall_id_valid",  {31'd0, b1.id_valid}, 32'd1);
        chk("stall_id_pc",     b1.id_pc, 32'h0);
        chk("stall_id_instr",  b1.id_instr, 32'hC0DE_0000);
      end
    end
    b1.id_ready = 1'b1;
    cyc();
    chk("resume_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("resume_req_addr",  b1.imem_req_addr, 32'h10);
    chk("drain_id_pc0",     b1.id_pc, 32'h4);
    cyc();
    wait_id("drain_valid1");
    chk("drain_id_pc1", b1.id_pc, 32'h8);
    cyc();
    wait_id("drain_valid2");
    chk("drain_id_pc2", b1.id_pc, 32'hC);
    cyc();
    wait_id("drain_valid3");
    chk("drain_id_pc3", b1.id_pc, 32'h10);

    // Redirect with entries buffered and a response landing: id_valid masked, then flushed
    rv1 = 1'b1; rpc1 = 32'h40;
    #1;
    chk("redir_mask_id_valid", {31'd0, b1.id_valid}, 32'd0);
    chk("redir_mask_req_valid", {31'd0, b1.imem_req_valid}, 32'd0);
    cyc();
    rv1 = 1'b0;
    #1;
    chk("flush_id_valid", {31'd0, b1.id_valid}, 32'd0);
    chk("flush_req_addr", b1.imem_req_addr, 32'h40);

    // Redirect to 0x100 while the 0x8 request is outstanding (k=2)
    rst = 1'b1;
    lat1 = 2;
    cyc();
    rst = 1'b0;
    wait_id("k2_valid0");
    chk("k2_id_pc0", b1.id_pc, 32'h0);
    cyc();
    wait_id("k2_valid1");
    chk("k2_id_pc1", b1.id_pc, 32'h4);
    chk("k2_req_addr8", b1.imem_req_addr, 32'h8);
    cyc();
    rv1 = 1'b1; rpc1 = 32'h100;
    #1;
    chk("drop_redir_req_valid", {31'd0, b1.imem_req_valid}, 32'd0);
    cyc();
    rv1 = 1'b0;
    #1;
    chk("drop_rsp_req_valid", {31'd0, b1.imem_req_valid}, 32'd0);
    chk("drop_rsp_id_valid",  {31'd0, b1.id_valid}, 32'd0);
    cyc();
    chk("drop_next_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("drop_next_req_addr",  b1.imem_req_addr, 32'h100);
    chk("drop_next_id_valid",  {31'd0, b1.id_valid}, 32'd0);
    wait_id("drop_valid100");
    chk("drop_id_pc",    b1.id_pc, 32'h100);
    chk("drop_id_instr", b1.id_instr, 32'hC0DE_0100);

    // Redirect to 0x203 in the cycle the 0x104 response arrives
    cyc();
    cyc();
    rv1 = 1'b1; rpc1 = 32'h203;
    #1;
    chk("same_redir_id_valid", {31'd0, b1.id_valid}, 32'd0);
    cyc();
    rv1 = 1'b0;
    #1;
    chk("same_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("same_req_addr",  b1.imem_req_addr, 32'h200);
    chk("same_id_valid",  {31'd0, b1.id_valid}, 32'd0);
    cyc();
    chk("same_no_stale",  {31'd0, b1.id_valid}, 32'd0);
    wait_id("same_valid200");
    chk("same_id_pc",    b1.id_pc, 32'h200);
    chk("same_id_instr", b1.id_instr, 32'hC0DE_0200);

    // Reset with 0x204 outstanding; the late response must be ignored
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b1.imem_req_ready = 1'b0;
    #1;
    chk("prst_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("prst_req_addr",  b1.imem_req_addr, 32'h0);
    chk("prst_id_valid",  {31'd0, b1.id_valid}, 32'd0);
    cyc();
    chk("hold_req_valid", {31'd0, b1.imem_req_valid}, 32'd1);
    chk("hold_req_addr",  b1.imem_req_addr, 32'h0);
    chk("late_rsp_id_valid", {31'd0, b1.id_valid}, 32'd0);
    b1.imem_req_ready = 1'b1;
    cyc();
    chk("late_id_valid2", {31'd0, b1.id_valid}, 32'd0);
    wait_id("prst_valid0");
    chk("prst_id_pc",    b1.id_pc, 32'h0);
    chk("prst_id_instr", b1.id_instr, 32'hC0DE_0000);
    chk("prst_id_pc4",   b1.id_pc_plus4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Instruction-fetch front end for the 5-stage pipelined RV32I core, directly upstream of the IF/ID register and decode. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel with a variable-latency response, and buffers fetched instructions with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake and flushes on branch/jump redirects from execute.

Parameters:
XLEN, 32, datapath and address width.
RESET_PC, 32'h0000_0000, fetch address after reset.
FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  imem accepts request this cycle.
imem_req_addr  out  XLEN  word-aligned fetch address (equals fetch_pc).
imem_rsp_valid  in  1  response data valid.
imem_rsp_data  in  32  fetched instruction.
redirect_valid  in  1  branch/jump taken; flush and refetch.
redirect_pc  in  XLEN  redirect target.
id_valid  out  1  instruction available to decode.
id_ready  in  1  decode accepts (low = stall).
id_instr  out  32  head instruction.
id_pc  out  XLEN  PC of head instruction.
id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset: synchronous on rst high. fetch_pc=RESET_PC, FIFO count=0, outstanding=0, drop=0. While rst is high: imem_req_valid=0, id_valid=0, imem_req_addr=RESET_PC, id_instr/id_pc/id_pc_plus4=0.
- Reset mid-operation: a response to a pre-reset request arrives with outstanding=0 and is ignored.
- Outstanding requests: at most one.
- Request rule: imem_req_valid = !rst && !redirect_valid && !outstanding && (count < FIFO_DEPTH).
- Request handshake (imem_req_valid && imem_req_ready):
  - outstanding<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - fetch_pc wraps from 32'hFFFF_FFFC to 0.
  - imem_req_addr must stay stable while imem_req_valid is high and imem_req_ready is low.
- Response:
  - Legal no earlier than the cycle after acceptance. imem_rsp_valid with outstanding=0 is ignored.
  - On a response, outstanding<=0.
  - drop=1: discard the data and clear drop.
  - drop=0: push {req_pc, imem_rsp_data} into the FIFO.
  - Space is always reserved, because a request is only issued when count < FIFO_DEPTH.
- Output: id_valid = (count != 0) && !redirect_valid. id_instr, id_pc and id_pc_plus4 come from the head entry. Pop on id_valid && id_ready.
- Simultaneous push and pop: count is unchanged and the ordering is preserved. Pointers wrap modulo FIFO_DEPTH.
- Stall: with id_ready low, the head entry and the id_* outputs hold stable. Fetch continues until the FIFO is full.
- Redirect (highest priority after rst), in the cycle redirect_valid=1:
  - FIFO flushed (count=0, pointers reset), no pop, no push.
  - fetch_pc<=redirect_pc with bits[1:0] forced to 00.
  - If outstanding and no response this cycle: drop<=1.
  - If a response arrives the same cycle: it is discarded, outstanding<=0, drop<=0.
- Back-to-back redirects: the last one wins. drop remains set until the one stale response returns.
- Latency:
  - Request accepted at cycle N, response at N+k (k ≥ 1): id_valid=1 at N+k+1.
  - Redirect at cycle R with no outstanding request: imem_req_valid=1 with the new address at R+1.
- Throughput: one instruction per (k+1) cycles at most. This is accepted for this revision.

Test Plan:
- Reset then free-run with imem_req_ready=1, k=1, id_ready=1 -> requests to 0x0, 0x4, 0x8…; decode receives id_pc 0x0, 0x4, 0x8 in order with matching instructions, and id_pc_plus4=id_pc+4.
- Hold id_ready=0 for 12 cycles -> exactly 4 entries fill (FIFO_DEPTH=4), then imem_req_valid=0 and id_* stay stable. On release, the 4 entries drain in order and fetch resumes at 0x10.
- Redirect to 0x100 while a request for 0x8 is outstanding (response 2 cycles later) -> the 0x8 response is dropped, the FIFO is empty, the next request goes to 0x100, and the next id_pc is 0x100.
- Redirect to 0x203 in the same cycle a response arrives -> the response is discarded, the next request address is 0x200, and no stale id_valid appears.
- Set RESET_PC=32'hFFFF_FFF8 and run 3 fetches -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 for FFFF_FFFC is 0.
- Assert rst for 1 cycle while a request is outstanding, then return a late response -> the response is ignored, id_valid stays 0, and the first post-reset request goes to RESET_PC.
